// File: rtl/alu_74x181_nibble_sequencer.sv
// Sequences one shared 4-bit 74x181 slice across a WIDTH-bit operand pair,
// one nibble per clock LSB first, chaining the active-low carry between passes.
module alu_74x181_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             ci_bar,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_s,
   output logic             alu_m,
   output logic             alu_ci_bar,
   input  logic [3:0]       alu_f,
   input  logic             alu_co_bar,
   input  logic             alu_aeqb,
   output logic [WIDTH-1:0] f,
   output logic             co_bar,
   output logic             aeqb,
   output logic             busy,
   output logic             done
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int CW      = $clog2(NIBBLES);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r, b_r;
   logic [3:0]       s_r;
   logic             m_r;
   logic             carry;

   // cnt is parked at 0 outside RUN, so the slice then sees nibble 0
   assign alu_a      = a_r[{cnt, 2'b00} +: 4];
   assign alu_b      = b_r[{cnt, 2'b00} +: 4];
   assign alu_s      = s_r;
   assign alu_m      = m_r;
   assign alu_ci_bar = carry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         s_r    <= '0;
         m_r    <= 1'b1;
         carry  <= 1'b1;
         f      <= '0;
         co_bar <= 1'b1;
         aeqb   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, FIN: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
                  s_r   <= s;
                  m_r   <= m;
                  carry <= ci_bar;
                  cnt   <= '0;
                  aeqb  <= 1'b1;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               f[{cnt, 2'b00} +: 4] <= alu_f;
               carry <= alu_co_bar;
               aeqb  <= aeqb & alu_aeqb;
               if (cnt == LAST) begin
                  co_bar <= alu_co_bar;
                  cnt    <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= FIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_74x181_nibble_sequencer.sv
// Bench for the nibble sequencer: a 74x181 slice model closes the loop, and
// results are checked against a word-wide model of the same function table.
module tb_alu_74x181_nibble_sequencer;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  a_i = '0, b_i = '0;
   logic [3:0]    s_i = '0;
   logic          m_i = 1'b0, ci_i = 1'b1;
   logic [3:0]    alu_a, alu_b, alu_s, alu_f;
   logic          alu_m, alu_ci_bar, alu_co_bar, alu_aeqb;
   logic [W-1:0]  f;
   logic          co_bar, aeqb, busy, done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_74x181_nibble_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .s(s_i), .m(m_i),
      .ci_bar(ci_i), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
      .alu_ci_bar(alu_ci_bar), .alu_f(alu_f), .alu_co_bar(alu_co_bar),
      .alu_aeqb(alu_aeqb), .f(f), .co_bar(co_bar), .aeqb(aeqb), .busy(busy),
      .done(done)
   );

   // 74x181 slice, bitwise ripple form (active-high data)
   logic [3:0] px, gy;
   logic [4:0] cy;
   always_comb begin
      px = '0;
      gy = '0;
      cy = '0;
      alu_f = '0;
      cy[0] = ~alu_ci_bar;
      for (int i = 0; i < 4; i++) begin
         px[i] = alu_a[i] | (alu_b[i] & alu_s[0]) | (~alu_b[i] & alu_s[1]);
         gy[i] = (alu_a[i] & ~alu_b[i] & alu_s[2]) | (alu_a[i] & alu_b[i] & alu_s[3]);
         alu_f[i] = alu_m ? ~(px[i] ^ gy[i]) : (px[i] ^ gy[i] ^ cy[i]);
         cy[i+1] = (px[i] & gy[i]) | (cy[i] & (px[i] ^ gy[i]));
      end
   end
   assign alu_co_bar = ~cy[4];
   assign alu_aeqb   = &alu_f;

   // word-wide reference: {aeqb, co_bar, f}
   function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] s, input logic m, input logic ci);
      logic [W-1:0] x, y, r;
      logic [W:0]   sum;
      x   = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
      y   = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
      sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~ci};
      r   = m ? ~(x ^ y) : sum[W-1:0];
      return {&r, ~sum[W], r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic scramble();
      a_i  = W'($urandom);
      b_i  = W'($urandom);
      s_i  = 4'($urandom);
      m_i  = 1'($urandom);
      ci_i = 1'($urandom);
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m, input logic ci);
      a_i = a; b_i = b; s_i = s; m_i = m; ci_i = ci;
   endtask

   // start one op; operands are scrambled during RUN to prove they were latched
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                         input logic m, input logic ci, output int lat, output int bcnt);
      @(negedge clk);
      drive(a, b, s, m, ci);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();
      lat = 1;
      bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] s, input logic m, input logic ci);
      int lat, bcnt;
      logic [W+1:0] exp;
      exp = ref_op(a, b, s, m, ci);
      run_op(a, b, s, m, ci, lat, bcnt);
      chk({tag, "_lat"}, 32'(lat), 32'd5);
      chk({tag, "_res"}, 32'({aeqb, co_bar, f}), 32'(exp));
   endtask

   initial begin
      int lat, bcnt, n, dones;
      logic [W+1:0] exp;

      repeat (2) @(negedge clk);
      chk("rst_f", 32'(f), 32'h0);
      chk("rst_flags", 32'({co_bar, aeqb, busy, done}), 32'b1000);
      chk("rst_alu_sm", 32'({alu_s, alu_m}), 32'b00001);
      rst = 1'b0;

      // add, with exact latency and busy width
      run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, lat, bcnt);
      chk("add_f", 32'(f), 32'h2233);
      chk("add_co", 32'(co_bar), 32'd1);
      chk("add_lat", 32'(lat), 32'd5);
      chk("add_busy", 32'(bcnt), 32'd4);
      @(negedge clk);
      chk("done_pulse", 32'({done, busy}), 32'b00);
      chk("hold_f", 32'(f), 32'h2233);

      run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, lat, bcnt);
      chk("ovf", 32'({co_bar, f}), 32'h00000);
      run_op(16'h5000, 16'h1234, 4'b0110, 1'b0, 1'b0, lat, bcnt);
      chk("sub", 32'({co_bar, f}), 32'h03DCC);
      run_op(16'hABCD, 16'hABCD, 4'b0110, 1'b0, 1'b1, lat, bcnt);
      chk("eq_hit", 32'({aeqb, f}), 32'h1FFFF);
      run_op(16'hABCD, 16'hABCC, 4'b0110, 1'b0, 1'b1, lat, bcnt);
      chk("eq_miss", 32'({aeqb, f}), 32'h00000);
      run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, lat, bcnt);
      chk("xor", 32'(f), 32'h0FF0);
      run_op(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b1, lat, bcnt);
      chk("and", 32'(f), 32'hF000);

      // start pulsed mid-RUN must be ignored
      @(negedge clk);
      drive(16'h0101, 16'h0202, 4'b1001, 1'b0, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("run_start_ignored", 32'(dones), 32'd1);
      chk("run_start_res", 32'(f), 32'h0303);

      // start held through DONE: back-to-back ops
      @(negedge clk);
      drive(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1);
      start = 1'b1;
      @(negedge clk);
      drive(16'h8000, 16'h8001, 4'b1001, 1'b0, 1'b0);
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_first_lat", 32'(n), 32'd5);
      chk("b2b_first", 32'({co_bar, f}), 32'h13333);
      @(negedge clk);
      start = 1'b0;
      scramble();
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_second_lat", 32'(n), 32'd5);
      chk("b2b_second", 32'({co_bar, f}), 32'h00002);

      // reset in the second RUN cycle aborts at once
      run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, lat, bcnt);
      @(negedge clk);
      drive(16'h4444, 16'h4444, 4'b1001, 1'b0, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_f", 32'(f), 32'h0);
      chk("abort_flags", 32'({co_bar, aeqb, busy, done}), 32'b1000);
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      chk("abort_quiet", 32'(dones), 32'd0);
      check_op("post_rst", 16'h00FF, 16'h0F01, 4'b1001, 1'b0, 1'b1);

      // randomized ops against the word-wide model
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic [3:0]   rs;
         logic         rm, rc;
         ra = W'($urandom);
         rb = (i % 5 == 0) ? ra : W'($urandom);
         rs = 4'($urandom);
         rm = 1'($urandom);
         rc = 1'($urandom);
         exp = ref_op(ra, rb, rs, rm, rc);
         run_op(ra, rb, rs, rm, rc, lat, bcnt);
         chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd5);
         chk($sformatf("rnd%0d_res", i), 32'({aeqb, co_bar, f}), 32'(exp));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
